corral_player_input: RTL and testbench
======================================

# corral_player_input

Player-side front end for the corral game core. It debounces two raw push-buttons (step, go) and lets the player dial a move distance of 1..5. It then drives the game core's enter/move/ready handshake as its initiator: present move, wait for acceptance, release enter, wait for the core to become ready again. It sits between the board button pins and the game core's `enter`/`move` inputs, and its `ready` input comes from the game core.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before a button level change is accepted (≥2).
- TIMEOUT_CYCLES, 8: cycles `enter` is held with `ready` still high before the move is declared rejected (≥2).
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- btn_step  input  1  raw step button, asynchronous, active-high.
- btn_go  input  1  raw submit button, asynchronous, active-high.
- ready  input  1  game core ready; high = core idle and accepting a move.
- enter  output  1  move request to the game core.
- move  output  3  move distance; equals latched move while `enter`=1, else 3'd0.
- sel_move  output  3  currently dialled distance, 1..5, for display.
- busy  output  1  high whenever FSM is not in SELECT.
- reject  output  1  one-cycle pulse: go refused or move timed out.

## Operation
- Input path per button:
  - 2-flop synchronizer, then debouncer with a counter of width $clog2(DEBOUNCE_CYCLES).
  - sync == db: counter cleared.
  - sync != db: counter increments. When the counter equals DEBOUNCE_CYCLES-1, `db` takes `sync` and the counter clears.
  - Press pulse = db & ~db_prev. It is one cycle per accepted rising level. Holding a button never repeats; releases produce no pulse.
- sel_move: reset 3'd1. A step press in SELECT increments it, wrapping 5→1. Step presses outside SELECT are discarded.
- FSM states: SELECT, ARM, RELEASE.
  - SELECT (enter=0)
    - go press with ready=1: latch sel_move into move register, go to ARM.
    - go press with ready=0: reject pulse, stay in SELECT.
  - ARM (enter=1, move=latched)
    - ready=0 sampled: game has accepted. Go to RELEASE, clear timeout counter.
    - ready=1 for TIMEOUT_CYCLES consecutive cycles (core refused, e.g. out-of-bounds move): reject pulse, go to SELECT.
  - RELEASE (enter=0)
    - Stays until ready=1 is sampled, then goes to SELECT.
    - Covers game WAIT, kick sequences and SETUP after game over; no timeout.
- Simultaneous step and go press in SELECT: go wins with the pre-increment sel_move; the step is discarded.
- Go press in ARM/RELEASE: ignored, no reject.
- sel_move is not altered by a submission; the player's last choice persists.

## Timing
- Reset values: enter=0, move=0, sel_move=1, busy=0, reject=0. FSM=SELECT, db=0, all counters 0.
- reset_n low mid-operation forces reset values asynchronously; enter drops immediately.
- Button latency: raw rise stable from edge 0 → db high after edge 2+DEBOUNCE_CYCLES.
- Press pulse is valid the following cycle; FSM/sel_move update at edge 3+DEBOUNCE_CYCLES.
- Bounces shorter than DEBOUNCE_CYCLES synchronized cycles produce no press.
- Acceptance: ready sampled low in ARM at edge k → enter=0 and move=0 after edge k.
- Return: ready sampled high in RELEASE at edge k → busy=0 after edge k. A new go press is accepted from the next cycle.
- Timeout: enter rises at edge a. With ready high throughout, reject=1 and enter=0 after edge a+TIMEOUT_CYCLES, and reject clears one cycle later.
- All outputs registered; no combinational path from ready or buttons to outputs.

## Test plan
- Reset/idle (DEBOUNCE_CYCLES=4): release reset, no buttons → enter=0, move=0, sel_move=1, busy=0, reject=0 for 50 cycles.
- Debounce: btn_step glitches of 1–3 cycles → sel_move stays 1. Four clean 10-cycle presses → sel_move 2,3,4,5. Fifth press → wraps to 1.
- Accept handshake: sel_move=3, ready=1, press go → enter=1, move=3 at edge 7 after raw rise. Bench drops ready 2 cycles later → enter=0, move=0 next edge, busy=1. Ready high → busy=0.
- Reject paths: go with ready=0 → reject pulses once, enter stays 0. Go with ready held 1 (TIMEOUT_CYCLES=8) → enter high exactly 8 cycles, then reject pulse, FSM in SELECT.
- Simultaneous/ignored presses: step+go same cycle with sel_move=2 → move=2 sent, sel_move stays 2. Step/go pressed during RELEASE → no effect, no reject.
- Reset mid-ARM: assert reset_n low while enter=1 → enter=0 asynchronously, sel_move=1 after release.

Source files
------------

// File: rtl/corral_player_input.sv
// Player-side front end for the corral game core: debounces step/go buttons,
// dials a move distance 1..5 and drives the core's enter/move/ready handshake.
module corral_player_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 8
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_btn_step,
  input  logic       i_btn_go,
  input  logic       i_ready,
  output logic       o_enter,
  output logic [2:0] o_move,
  output logic [2:0] o_sel_move,
  output logic       o_busy,
  output logic       o_reject
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_SELECT, S_ARM, S_RELEASE} state_t;

  logic [1:0] w_raw;
  logic [1:0] w_press;
  logic       w_step;
  logic       w_go;

  assign w_raw  = {i_btn_go, i_btn_step};
  assign w_step = w_press[0];
  assign w_go   = w_press[1];

  // Bit 0 is step, bit 1 is go; each gets its own synchronizer and debouncer.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_db;
      logic            r_db_prev;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_sync1   <= 1'b0;
          r_sync2   <= 1'b0;
          r_db      <= 1'b0;
          r_db_prev <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_sync1   <= w_raw[gi];
          r_sync2   <= r_sync1;
          r_db_prev <= r_db;
          if (r_sync2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_db & ~r_db_prev;
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_next;
  logic [2:0]      r_sel;
  logic [2:0]      w_sel_next;
  logic [2:0]      r_move_lat;
  logic            w_latch;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_next;
  logic            w_timeout;
  logic            r_enter;
  logic            r_busy;
  logic            r_reject;
  logic            w_enter_next;
  logic            w_busy_next;
  logic            w_reject_next;

  assign w_timeout = (r_state == S_ARM) && i_ready && (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_SELECT;
      r_sel      <= 3'd1;
      r_move_lat <= 3'd0;
      r_to_cnt   <= '0;
      r_enter    <= 1'b0;
      r_busy     <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_sel    <= w_sel_next;
      r_to_cnt <= w_to_next;
      r_enter  <= w_enter_next;
      r_busy   <= w_busy_next;
      r_reject <= w_reject_next;
      if (w_latch) r_move_lat <= r_sel;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SELECT:  if (w_go && i_ready) w_state_next = S_ARM;
      S_ARM: begin
        if (!i_ready)       w_state_next = S_RELEASE;
        else if (w_timeout) w_state_next = S_SELECT;
      end
      S_RELEASE: if (i_ready) w_state_next = S_SELECT;
      default:   w_state_next = S_SELECT;
    endcase
  end

  // Go has priority over a coincident step, so the pre-increment value is sent.
  always_comb begin
    w_latch       = (r_state == S_SELECT) && w_go && i_ready;
    w_enter_next  = (w_state_next == S_ARM);
    w_busy_next   = (w_state_next != S_SELECT);
    w_reject_next = ((r_state == S_SELECT) && w_go && !i_ready) || w_timeout;
    w_sel_next    = r_sel;
    if ((r_state == S_SELECT) && w_step && !w_go)
      w_sel_next = (r_sel == 3'd5) ? 3'd1 : r_sel + 3'd1;
    w_to_next = '0;
    if ((r_state == S_ARM) && (w_state_next == S_ARM))
      w_to_next = r_to_cnt + 1'b1;
  end

  assign o_enter    = r_enter;
  assign o_move     = r_enter ? r_move_lat : 3'd0;
  assign o_sel_move = r_sel;
  assign o_busy     = r_busy;
  assign o_reject   = r_reject;

endmodule

// File: tb/tb_corral_player_input.sv
// Scoreboard bench for corral_player_input: expected submissions and rejects are
// queued as stimulus is driven and matched when the DUT raises enter or reject.
module tb_corral_player_input;

  localparam int DB = 4;
  localparam int TO = 8;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_go   = 1'b0;
  logic       ready    = 1'b1;
  logic       enter;
  logic       busy;
  logic       reject;
  logic [2:0] move;
  logic [2:0] sel_move;

  int n_tests = 0;
  int n_fail  = 0;

  // kind 0 = submission (val = move), kind 1 = reject pulse
  typedef struct {int kind; int val;} exp_t;
  exp_t exp_q[$];
  logic prev_enter = 1'b0;

  always #5 clock = ~clock;

  corral_player_input #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_btn_step(btn_step),
    .i_btn_go  (btn_go),
    .i_ready   (ready),
    .o_enter   (enter),
    .o_move    (move),
    .o_sel_move(sel_move),
    .o_busy    (busy),
    .o_reject  (reject)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic press_step();
    btn_step = 1'b1;
    tick(10);
    btn_step = 1'b0;
    tick(10);
  endtask

  task automatic wait_enter(input string tag);
    for (int i = 0; i < 20 && !enter; i++) tick(1);
    check(tag, enter, 1);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (enter && !prev_enter) begin
        $display("[TB] enter move=%0d sel_move=%0d", move, sel_move);
        check("ev_pending_enter", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("ev_kind_enter", exp_q[0].kind, 0);
          check("ev_move", move, exp_q[0].val);
          void'(exp_q.pop_front());
        end
      end
      if (reject) begin
        $display("[TB] reject pulse");
        check("ev_pending_reject", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("ev_kind_reject", exp_q[0].kind, 1);
          void'(exp_q.pop_front());
        end
      end
    end
    prev_enter <= enter;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int hi;
    // Reset state while held in reset
    tick(3);
    check("rst_outputs", {enter, busy, reject, move, sel_move}, {3'b000, 3'd0, 3'd1});
    reset_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      check("idle", {enter, busy, reject, move, sel_move}, {3'b000, 3'd0, 3'd1});
    end

    // Glitches of 1..3 cycles never register
    for (int g = 1; g <= 3; g++) begin
      btn_step = 1'b1;
      tick(g);
      btn_step = 1'b0;
      tick(10);
      check("glitch_sel", sel_move, 1);
    end
    for (int p = 2; p <= 5; p++) begin
      press_step();
      check("step_sel", sel_move, p);
    end
    press_step();
    check("step_wrap", sel_move, 1);

    // Accept handshake with sel_move=3
    press_step();
    press_step();
    check("sel_before_go", sel_move, 3);
    push(0, 3);
    btn_go = 1'b1;
    tick(6);
    check("enter_early", enter, 0);
    tick(1);
    check("enter_edge7", enter, 1);
    check("move_edge7", move, 3);
    check("busy_arm", busy, 1);
    tick(2);
    ready = 1'b0;
    tick(1);
    check("accept_enter", enter, 0);
    check("accept_move", move, 0);
    check("accept_busy", busy, 1);
    btn_go = 1'b0;
    tick(12);
    // Presses during RELEASE are ignored
    btn_step = 1'b1;
    btn_go   = 1'b1;
    tick(10);
    btn_step = 1'b0;
    btn_go   = 1'b0;
    tick(10);
    check("release_sel", sel_move, 3);
    check("release_busy", busy, 1);
    check("release_enter", enter, 0);
    ready = 1'b1;
    tick(1);
    check("return_busy", busy, 0);

    // Go while core not ready
    ready = 1'b0;
    push(1, 0);
    btn_go = 1'b1;
    tick(10);
    check("nready_enter", enter, 0);
    check("nready_busy", busy, 0);
    btn_go = 1'b0;
    tick(10);
    ready = 1'b1;
    tick(2);

    // Timeout with ready held high
    push(0, 3);
    push(1, 0);
    btn_go = 1'b1;
    wait_enter("to_enter_seen");
    btn_go = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (!enter) break;
      hi++;
      tick(1);
    end
    check("to_enter_cycles", hi, TO);
    check("to_reject", reject, 1);
    check("to_busy", busy, 0);
    tick(1);
    check("to_reject_clear", reject, 0);
    tick(10);

    // Simultaneous step+go with sel_move=2
    for (int p = 0; p < 4; p++) press_step();
    check("sel_two", sel_move, 2);
    push(0, 2);
    btn_step = 1'b1;
    btn_go   = 1'b1;
    wait_enter("sim_enter_seen");
    check("sim_move", move, 2);
    ready = 1'b0;
    btn_step = 1'b0;
    btn_go   = 1'b0;
    tick(1);
    check("sim_accept_enter", enter, 0);
    tick(12);
    ready = 1'b1;
    tick(2);
    check("sim_sel", sel_move, 2);
    check("sim_busy", busy, 0);

    // Asynchronous reset while enter is high
    push(0, 2);
    btn_go = 1'b1;
    wait_enter("rst_enter_seen");
    btn_go = 1'b0;
    tick(1);
    check("rst_enter_before", enter, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_enter", enter, 0);
    check("rst_async_move", move, 0);
    check("rst_async_busy", busy, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("rst_sel", sel_move, 1);
    check("rst_enter_after", enter, 0);

    tick(5);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
